// File: rtl/c_nibble_tx_pkg.sv
// c_nibble_tx shared types: serial FSM states and frame constants.
// Imported by the top level and the serial shifter.
package c_nibble_tx_pkg;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } tx_state_e;

  // start + 8 data + stop
  localparam int unsigned FRAME_BITS = 10;
  localparam int unsigned DATA_BITS  = FRAME_BITS - 2;

  function automatic logic [7:0] pack_nib(
    input logic [3:0] hi,
    input logic [3:0] lo
  );
    return {hi, lo};
  endfunction

endpackage

// File: rtl/c_nibble_tx_if.sv
// c_nibble_tx bus: nibble stream and overflow clear in, serial line,
// busy and sticky overflow out. master = producer, slave = transmitter.
interface c_nibble_tx_if;

  logic [3:0] pi_c;
  logic       pi_c_vld;
  logic       pi_ovf_clr;
  logic       po_tx;
  logic       po_busy;
  logic       po_ovf;

  modport master (
    output pi_c,
    output pi_c_vld,
    output pi_ovf_clr,
    input  po_tx,
    input  po_busy,
    input  po_ovf
  );

  modport slave (
    input  pi_c,
    input  pi_c_vld,
    input  pi_ovf_clr,
    output po_tx,
    output po_busy,
    output po_ovf
  );

endinterface

// File: rtl/c_tx_shift.sv
// c_tx_shift: 8N1 serialiser. Ports: clk, rst_n, hold_full_i/hold_i (byte
// on offer), take_o (byte consumed this cycle), tx_o (line), idle_o.
module c_tx_shift #(
  parameter int unsigned BIT_CNT = 4,
  parameter int unsigned CNT_W   = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       hold_full_i,
  input  logic [7:0] hold_i,
  output logic       take_o,
  output logic       tx_o,
  output logic       idle_o
);

  import c_nibble_tx_pkg::*;

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BIT_CNT - 1);
  localparam logic [2:0]       IDX_MAX = 3'(DATA_BITS - 1);

  tx_state_e        state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [2:0]       idx_q;
  logic [7:0]       shift_q;
  logic             tx_q;
  logic             bit_end;

  assign bit_end = (cnt_q == CNT_MAX);

  // A waiting byte is taken from IDLE or at the last clock of the stop
  // bit, so back-to-back frames have no idle gap.
  assign take_o = hold_full_i &
                  ((state_q == IDLE) |
                   ((state_q == STOP) & bit_end));

  assign tx_o   = tx_q;
  assign idle_o = (state_q == IDLE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (hold_full_i) begin
            state_q <= START;
            shift_q <= hold_i;
            cnt_q   <= '0;
            tx_q    <= 1'b0;
          end
        end
        START: begin
          if (bit_end) begin
            state_q <= DATA;
            idx_q   <= '0;
            cnt_q   <= '0;
            tx_q    <= shift_q[0];
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        DATA: begin
          if (bit_end) begin
            cnt_q <= '0;
            if (idx_q == IDX_MAX) begin
              state_q <= STOP;
              tx_q    <= 1'b1;
            end else begin
              idx_q <= idx_q + 3'd1;
              tx_q  <= shift_q[idx_q + 3'd1];
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        STOP: begin
          if (bit_end) begin
            cnt_q <= '0;
            if (hold_full_i) begin
              state_q <= START;
              shift_q <= hold_i;
              tx_q    <= 1'b0;
            end else begin
              state_q <= IDLE;
              tx_q    <= 1'b1;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          tx_q    <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: rtl/c_nibble_tx.sv
// c_nibble_tx: packs AND-stage nibbles into bytes, holds one, sends 8N1.
// Ports: clk, rst_n, bus (slave: pi_c/pi_c_vld/pi_ovf_clr, po_tx/busy/ovf).
module c_nibble_tx #(
  parameter int unsigned BIT_CNT = 4,
  parameter int unsigned CNT_W   = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  c_nibble_tx_if.slave   bus
);

  import c_nibble_tx_pkg::*;

  logic       phase_q, phase_d;
  logic [3:0] low_q,   low_d;
  logic [7:0] hold_q,  hold_d;
  logic       full_q,  full_d;
  logic       ovf_q,   ovf_d;

  logic       new_byte;
  logic       drop;
  logic       take;
  logic       tx;
  logic       idle;

  assign new_byte = bus.pi_c_vld & phase_q;
  // Hold still occupied and not being drained: the new byte is lost.
  assign drop     = new_byte & full_q & ~take;

  always_comb begin
    phase_d = phase_q;
    low_d   = low_q;
    hold_d  = hold_q;
    full_d  = (full_q & ~take) | new_byte;
    ovf_d   = ovf_q;
    if (bus.pi_c_vld) begin
      phase_d = ~phase_q;
      if (!phase_q) low_d = bus.pi_c;
    end
    if (new_byte & ~drop) hold_d = pack_nib(bus.pi_c, low_q);
    // set has priority over clear
    if (drop)                ovf_d = 1'b1;
    else if (bus.pi_ovf_clr) ovf_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      phase_q <= 1'b0;
      low_q   <= '0;
      hold_q  <= '0;
      full_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      phase_q <= phase_d;
      low_q   <= low_d;
      hold_q  <= hold_d;
      full_q  <= full_d;
      ovf_q   <= ovf_d;
    end
  end

  c_tx_shift #(
    .BIT_CNT (BIT_CNT),
    .CNT_W   (CNT_W)
  ) u_shift (
    .clk         (clk),
    .rst_n       (rst_n),
    .hold_full_i (full_q),
    .hold_i      (hold_q),
    .take_o      (take),
    .tx_o        (tx),
    .idle_o      (idle)
  );

  assign bus.po_tx   = tx;
  assign bus.po_busy = ~idle | full_q;
  assign bus.po_ovf  = ovf_q;

endmodule

// File: tb/tb_c_nibble_tx.sv
// tb_c_nibble_tx: table vectors, directed corner cases and random traffic
// against a frame-time reference model of c_nibble_tx.
module tb_c_nibble_tx;

  localparam int B = 4;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;
  bit   chk_on = 1'b0;

  always #5 clk = ~clk;

  c_nibble_tx_if bus ();

  c_nibble_tx #(
    .BIT_CNT (B),
    .CNT_W   (8)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic chk(input string nm, input logic [7:0] act,
                     input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic frame_bit(input logic [7:0] b, input int k);
    if (k == 0) return 1'b0;
    if (k <= 8) return b[k-1];
    return 1'b1;
  endfunction

  // Reference model: a frame is a byte plus a time offset into its
  // 10*B clock window; one pending byte; a half-byte latch.
  bit         m_active, m_pend_vld, m_half_vld, m_ovf;
  int         m_t;
  logic [7:0] m_byte, m_pend;
  logic [3:0] m_half;

  always @(posedge clk) begin
    bit         fend, tk, nb;
    logic [7:0] nbyte;
    if (!rst_n) begin
      m_active = 0; m_t = 0; m_pend_vld = 0;
      m_half_vld = 0; m_ovf = 0;
    end else begin
      fend  = m_active && (m_t == 10*B - 1);
      tk    = m_pend_vld && (!m_active || fend);
      nb    = bus.pi_c_vld && m_half_vld;
      nbyte = {bus.pi_c, m_half};
      if (tk) begin
        m_active = 1; m_t = 0; m_byte = m_pend; m_pend_vld = 0;
      end else if (fend) m_active = 0;
      else if (m_active) m_t++;
      if (nb && m_pend_vld) m_ovf = 1;
      else begin
        if (nb) begin m_pend = nbyte; m_pend_vld = 1; end
        if (bus.pi_ovf_clr) m_ovf = 0;
      end
      if (bus.pi_c_vld) begin
        if (m_half_vld) m_half_vld = 0;
        else begin m_half = bus.pi_c; m_half_vld = 1; end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      chk("model_tx", {7'd0, bus.po_tx},
          {7'd0, m_active ? frame_bit(m_byte, m_t / B) : 1'b1});
      chk("model_busy", {7'd0, bus.po_busy},
          {7'd0, m_active | m_pend_vld});
      chk("model_ovf", {7'd0, bus.po_ovf}, {7'd0, m_ovf});
    end
  end

  task automatic cyc(input logic v, input logic [3:0] c, input logic clr);
    bus.pi_c_vld   = v;
    bus.pi_c       = c;
    bus.pi_ovf_clr = clr;
    @(posedge clk);
    #1;
  endtask

  // Called right after the edge that completes a byte.
  task automatic check_frame(input logic [7:0] b);
    for (int k = 0; k < 10*B; k++) begin
      cyc(0, 4'h0, 0);
      chk("frame_tx", {7'd0, bus.po_tx}, {7'd0, frame_bit(b, k / B)});
      chk("frame_busy", {7'd0, bus.po_busy}, 8'd1);
    end
    cyc(0, 4'h0, 0);
    chk("frame_end_busy", {7'd0, bus.po_busy}, 8'd0);
    chk("frame_end_tx", {7'd0, bus.po_tx}, 8'd1);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (bus.po_busy !== 1'b0 && n < 400) begin
      cyc(0, 4'h0, 0);
      n++;
    end
    chk("idle_timeout", {7'd0, bus.po_busy}, 8'd0);
  endtask

  typedef struct {
    logic [3:0] lo;
    logic [3:0] hi;
    logic [7:0] byt;
  } vec_t;

  vec_t vecs[5];

  initial begin
    vecs[0] = '{4'h5, 4'hA, 8'hA5};
    vecs[1] = '{4'hF, 4'h0, 8'h0F};
    vecs[2] = '{4'h0, 4'h0, 8'h00};
    vecs[3] = '{4'hF, 4'hF, 8'hFF};
    vecs[4] = '{4'h3, 4'hC, 8'hC3};

    // reset with random traffic
    rst_n = 1'b0;
    cyc(0, 4'h0, 0);
    chk_on = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc(1'($urandom_range(0, 1)), 4'($urandom), 0);
      chk("rst_tx", {7'd0, bus.po_tx}, 8'd1);
      chk("rst_busy", {7'd0, bus.po_busy}, 8'd0);
      chk("rst_ovf", {7'd0, bus.po_ovf}, 8'd0);
    end
    rst_n = 1'b1;
    cyc(0, 4'h0, 0);
    chk("rel_tx", {7'd0, bus.po_tx}, 8'd1);
    chk("rel_busy", {7'd0, bus.po_busy}, 8'd0);

    // single frames from the table
    foreach (vecs[i]) begin
      cyc(1, vecs[i].lo, 0);
      cyc(1, vecs[i].hi, 0);
      check_frame(vecs[i].byt);
    end

    // back-to-back then overflow: nibbles 1..6
    for (int i = 1; i <= 4; i++) cyc(1, 4'(i), 0);
    chk("b2b_ovf", {7'd0, bus.po_ovf}, 8'd0);
    cyc(1, 4'h5, 0);
    chk("pre_drop_ovf", {7'd0, bus.po_ovf}, 8'd0);
    cyc(1, 4'h6, 0);
    chk("drop_ovf", {7'd0, bus.po_ovf}, 8'd1);
    // first frame started at edge 3 and ends at edge 42
    for (int i = 0; i < 36; i++) cyc(0, 4'h0, 0);
    chk("b2b_stop", {7'd0, bus.po_tx}, 8'd1);
    cyc(0, 4'h0, 0);
    chk("b2b_start", {7'd0, bus.po_tx}, 8'd0);
    chk("b2b_busy", {7'd0, bus.po_busy}, 8'd1);
    wait_idle();
    chk("drop_sticky", {7'd0, bus.po_ovf}, 8'd1);

    // overflow clear, then clear colliding with a drop
    cyc(0, 4'h0, 1);
    chk("clr_ovf", {7'd0, bus.po_ovf}, 8'd0);
    for (int i = 7; i <= 11; i++) cyc(1, 4'(i), 0);
    cyc(1, 4'hC, 1);
    chk("clr_vs_set", {7'd0, bus.po_ovf}, 8'd1);
    wait_idle();

    // reset during data bit 3, with a stray half byte pending
    cyc(1, 4'h5, 0);
    cyc(1, 4'hA, 0);
    cyc(1, 4'h3, 0);
    for (int i = 0; i < 17; i++) cyc(0, 4'h0, 0);
    rst_n = 1'b0;
    cyc(0, 4'h0, 0);
    rst_n = 1'b1;
    chk("midrst_tx", {7'd0, bus.po_tx}, 8'd1);
    chk("midrst_busy", {7'd0, bus.po_busy}, 8'd0);
    chk("midrst_ovf", {7'd0, bus.po_ovf}, 8'd0);
    cyc(1, 4'hF, 0);
    cyc(1, 4'h0, 0);
    check_frame(8'h0F);

    // random traffic at varying density, rare clears and resets
    for (int blk = 0; blk < 8; blk++) begin
      int dens = (blk % 3 == 0) ? 1 : (blk % 3 == 1) ? 3 : 12;
      for (int i = 0; i < 400; i++) begin
        rst_n = ($urandom_range(0, 499) != 0);
        cyc(1'($urandom_range(0, 31) < dens), 4'($urandom),
            1'($urandom_range(0, 63) == 0));
      end
    end
    rst_n = 1'b1;
    wait_idle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
